adder_nibble_sequencer: RTL and testbench

Multi-cycle controller that performs a W-bit addition by time-sharing one external 4-bit binary full adder slice (74LS83-style, fast-carry, with propagation delay). It presents one operand nibble pair per step, LSB nibble first, and waits a programmable settle time for the slice. It captures each sum nibble and carries c4 into the next step through a carry flop. It sits between a requester, using a start/busy/done handshake, and a single shared adder instance on the board-level datapath.

---
 rtl/adder_nibble_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_adder_nibble_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_nibble_sequencer.sv
// adder_nibble_sequencer: W-bit add (W = 4*NIBBLES) done one nibble at a time
// through a single shared external 4-bit full adder slice (74LS83 style).
// Ports: clk, reset (async, active high); start/op_a/op_b/cin request side;
//   add_a/add_b/add_c0 drive the slice, add_sum/add_c4 come back from it;
//   result/cout hold the final sum; busy/done report progress.
// Latency: done pulses NIBBLES*(SETTLE+1)+1 edges after the accepted start.
// Backpressure: start is only looked at in IDLE; a start while busy is dropped.
// Optional build macro ADDER_SEQ_SUBTRACT_EN adds port sub (A - B via ~B + 1)
//   and port ovf (signed two's-complement overflow of the final operation).
module adder_nibble_sequencer #(
  parameter int NIBBLES = 4,
  parameter int SETTLE  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   cin,
`ifdef ADDER_SEQ_SUBTRACT_EN
  input  logic                   sub,
  output logic                   ovf,
`endif
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_c0,
  input  logic [3:0]             add_sum,
  input  logic                   add_c4,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   busy,
  output logic                   done
);

  localparam int W = 4 * NIBBLES;
  localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;      // B as presented to the slice (inverted when subtracting)
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   result_q, result_d;
  logic [2:0]     idx_q, idx_d;
  logic [2:0]     nxt_idx;
  logic [3:0]     cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           done_q, done_d;
  logic [3:0]     add_a_q, add_a_d;
  logic [3:0]     add_b_q, add_b_d;
  logic           add_c0_q, add_c0_d;
  logic [W-1:0]   b_eff;
  logic           c_eff;
`ifdef ADDER_SEQ_SUBTRACT_EN
  logic           ovf_q, ovf_d;
`endif

  // Operand B and initial carry as they will actually be fed to the slice.
  always_comb begin
`ifdef ADDER_SEQ_SUBTRACT_EN
    b_eff = sub ? ~op_b : op_b;
    c_eff = sub ? 1'b1  : cin;
`else
    b_eff = op_b;
    c_eff = cin;
`endif
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
    add_a_d  = add_a_q;
    add_b_d  = add_b_q;
    add_c0_d = add_c0_q;
    nxt_idx  = idx_q + 3'd1;
`ifdef ADDER_SEQ_SUBTRACT_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = op_a;
          b_d      = b_eff;
          carry_d  = c_eff;
          acc_d    = '0;
          idx_d    = 3'd0;
          cnt_d    = 4'd0;
          // Present nibble 0 right away so the first EXEC cycle already
          // counts as settle time for the slice.
          add_a_d  = op_a[3:0];
          add_b_d  = b_eff[3:0];
          add_c0_d = c_eff;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == SETTLE_C) begin
          acc_d[4*idx_q +: 4] = add_sum;
          carry_d = add_c4;
          cnt_d   = 4'd0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d    = nxt_idx;
            add_a_d  = a_q[4*nxt_idx +: 4];
            add_b_d  = b_q[4*nxt_idx +: 4];
            add_c0_d = add_c4;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        result_d = acc_q;
        cout_d   = carry_q;
        done_d   = 1'b1;
`ifdef ADDER_SEQ_SUBTRACT_EN
        // Overflow: both slice operands share a sign that the sum does not.
        ovf_d    = (a_q[W-1] == b_q[W-1]) && (acc_q[W-1] != a_q[W-1]);
`endif
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      idx_q    <= 3'd0;
      cnt_q    <= 4'd0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
      add_a_q  <= 4'd0;
      add_b_q  <= 4'd0;
      add_c0_q <= 1'b0;
`ifdef ADDER_SEQ_SUBTRACT_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
      add_a_q  <= add_a_d;
      add_b_q  <= add_b_d;
      add_c0_q <= add_c0_d;
`ifdef ADDER_SEQ_SUBTRACT_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign add_a  = add_a_q;
  assign add_b  = add_b_q;
  assign add_c0 = add_c0_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign done   = done_q;
  assign busy   = (state_q != S_IDLE);
`ifdef ADDER_SEQ_SUBTRACT_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_adder_nibble_sequencer.sv
// tb_adder_nibble_sequencer: directed vectors for the nibble adder sequencer,
// with a behavioural 4-bit adder slice behind each instance. One instance uses
// the default parameters, a second uses NIBBLES=2, SETTLE=0.
module tb_adder_nibble_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] op_a, op_b;
  logic        cin;
  logic        sub;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_c0, add_c4;
  logic [15:0] result;
  logic        cout, busy, done;
  logic        ovf;

  logic        start2;
  logic [7:0]  op_a2, op_b2;
  logic        cin2;
  logic        sub2;
  logic [3:0]  add_a2, add_b2, add_sum2;
  logic        add_c02, add_c42;
  logic [7:0]  result2;
  logic        cout2, busy2, done2;
  logic        ovf2;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural adder slices.
  logic [4:0] slice1, slice2;
  assign slice1   = {1'b0, add_a}  + {1'b0, add_b}  + {4'b0, add_c0};
  assign add_sum  = slice1[3:0];
  assign add_c4   = slice1[4];
  assign slice2   = {1'b0, add_a2} + {1'b0, add_b2} + {4'b0, add_c02};
  assign add_sum2 = slice2[3:0];
  assign add_c42  = slice2[4];

  adder_nibble_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef ADDER_SEQ_SUBTRACT_EN
    .sub(sub), .ovf(ovf),
`endif
    .add_a(add_a), .add_b(add_b), .add_c0(add_c0),
    .add_sum(add_sum), .add_c4(add_c4),
    .result(result), .cout(cout), .busy(busy), .done(done)
  );

  adder_nibble_sequencer #(.NIBBLES(2), .SETTLE(0)) dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .op_a(op_a2), .op_b(op_b2), .cin(cin2),
`ifdef ADDER_SEQ_SUBTRACT_EN
    .sub(sub2), .ovf(ovf2),
`endif
    .add_a(add_a2), .add_b(add_b2), .add_c0(add_c02),
    .add_sum(add_sum2), .add_c4(add_c42),
    .result(result2), .cout(cout2), .busy(busy2), .done(done2)
  );

`ifndef ADDER_SEQ_SUBTRACT_EN
  assign ovf  = 1'b0;
  assign ovf2 = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation on the default instance; call just after a negedge.
  // lat = edges from accept to done (-1 if done never came); c0s[i] = add_c0 in step i.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic s, output int lat, output logic [3:0] c0s);
    op_a = a; op_b = b; cin = c; sub = s; start = 1'b1;
    lat = -1; c0s = 4'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (((k - 1) % 2 == 0) && ((k - 1) / 2 < 4)) c0s[(k - 1) / 2] = add_c0;
      if (done) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    logic [3:0] c0s;
    int done_cnt, busy_low, t_done[3];
    int seen;

    reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
    start2 = 1'b0; op_a2 = '0; op_b2 = '0; cin2 = 1'b0; sub2 = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_result", 32'(result), 32'h0);
    check_eq("rst_cout",   32'(cout),   32'h0);
    check_eq("rst_busy",   32'(busy),   32'h0);
    check_eq("rst_done",   32'(done),   32'h0);
    check_eq("rst_add",    32'({add_a, add_b, add_c0}), 32'h0);
    check_eq("rst_ovf",    32'(ovf),    32'h0);
    reset = 1'b0;
    @(negedge clk);

    // 1: plain add, no carries anywhere
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat, c0s);
    check_eq("t1_lat",    32'(lat),    32'd9);
    check_eq("t1_result", 32'(result), 32'h5555);
    check_eq("t1_cout",   32'(cout),   32'h0);
    check_eq("t1_c0seq",  32'(c0s),    32'h0);
    check_eq("t1_busy_in_done", 32'(busy), 32'h0);
    @(negedge clk);
    check_eq("t1_idle_hold_add", 32'({add_a, add_b}), 32'h14);

    // 2: carry ripple through every nibble
    op_a = 16'hFFFF; op_b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    check_eq("t2_busy_after_start", 32'(busy), 32'h1);
    check_eq("t2_result_held", 32'(result), 32'h5555);
    start = 1'b0;
    repeat (12) @(negedge clk);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, c0s);
    check_eq("t2a_lat",    32'(lat),    32'd9);
    check_eq("t2a_result", 32'(result), 32'h0);
    check_eq("t2a_cout",   32'(cout),   32'h1);
    check_eq("t2a_c0seq",  32'(c0s),    32'b1110);
    @(negedge clk);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, lat, c0s);
    check_eq("t2b_result", 32'(result), 32'h0);
    check_eq("t2b_cout",   32'(cout),   32'h1);
    check_eq("t2b_c0seq",  32'(c0s),    32'b1111);
    @(negedge clk);

    // 3: start held high -> back-to-back operations
    op_a = 16'h0001; op_b = 16'h0002; cin = 1'b0; start = 1'b1;
    done_cnt = 0; busy_low = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (!busy) busy_low++;
      if (done) begin
        if (done_cnt < 3) t_done[done_cnt] = k;
        done_cnt++;
        check_eq("t3_result", 32'(result), 32'h3);
      end
    end
    start = 1'b0;
    check_eq("t3_done_cnt", 32'(done_cnt), 32'd3);
    check_eq("t3_busy_low", 32'(busy_low), 32'd3);
    if (done_cnt >= 3) begin
      check_eq("t3_gap1", 32'(t_done[1] - t_done[0]), 32'd10);
      check_eq("t3_gap2", 32'(t_done[2] - t_done[1]), 32'd10);
    end else begin
      check_eq("t3_done_pulses", 32'(done_cnt), 32'd3);
    end
    repeat (2) @(negedge clk);

    // 4: reset in the middle of an operation
    op_a = 16'h1234; op_b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("t4_result", 32'(result), 32'h0);
    check_eq("t4_cout",   32'(cout),   32'h0);
    check_eq("t4_busy",   32'(busy),   32'h0);
    check_eq("t4_add",    32'({add_a, add_b, add_c0}), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check_eq("t4_no_done", 32'(seen), 32'd0);
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat, c0s);
    check_eq("t4_lat",    32'(lat),    32'd9);
    check_eq("t4_result2", 32'(result), 32'h0100);
    check_eq("t4_cout2",   32'(cout),   32'h0);
    @(negedge clk);

    // 5: NIBBLES=2, SETTLE=0 instance
    op_a2 = 8'hAB; op_b2 = 8'h55; cin2 = 1'b0; start2 = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start2 = 1'b0;
      if (done2) begin
        lat = k - 1;
        break;
      end
    end
    check_eq("t5_lat",    32'(lat),     32'd3);
    check_eq("t5_result", 32'(result2), 32'h00);
    check_eq("t5_cout",   32'(cout2),   32'h1);
    @(negedge clk);

`ifdef ADDER_SEQ_SUBTRACT_EN
    // 6: subtract mode
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat, c0s);
    check_eq("t6a_result", 32'(result), 32'hFFFE);
    check_eq("t6a_cout",   32'(cout),   32'h0);
    check_eq("t6a_ovf",    32'(ovf),    32'h0);
    @(negedge clk);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat, c0s);
    check_eq("t6b_result", 32'(result), 32'h7FFF);
    check_eq("t6b_cout",   32'(cout),   32'h1);
    check_eq("t6b_ovf",    32'(ovf),    32'h1);
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
